// File: rtl/dms_sar_pkg.sv
// Shared types and constants for the dms_sar_adc successive-approximation converter.
package dms_sar_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } sar_state_t;

    // A real input that is not below this is treated as an undriven (X/Z) node.
    localparam real DMS_XZ_LIMIT = 1e20;

endpackage

// File: rtl/dms_sar_cmp.sv
// Trial-code comparator: keeps a bit when the held input reaches trial*vref/2**NBITS.
// Latency: combinational. Backpressure: none.
// Keeps the real arithmetic out of the control FSM.
module dms_sar_cmp #(
    parameter int NBITS = 8
) (
    input  real              vin_h,
    input  real              vref_h,
    input  logic [NBITS-1:0] trial,
    output logic             keep
);
    import dms_sar_pkg::*;

    localparam real SCALE = 2.0 ** NBITS;

    always_comb begin
        keep = (vin_h >= (real'(trial) * vref_h / SCALE));
    end

endmodule

// File: rtl/dms_sar_adc.sv
// SAR ADC model: samples the loop-filter voltage, resolves NBITS MSB-first, pulses valid with the code.
// Latency: start at edge k -> valid at edge k+NBITS+2 (k+4*(NBITS+1)+1 with DMS_SAR_ADC_AVG_EN averaging).
// Backpressure: none; start is ignored while busy, and a start in DONE chains the next conversion.
module dms_sar_adc #(
    parameter int  NBITS    = 8,
    parameter real VREF_NOM = 1.0,
    parameter real TCLK     = 1e-9
) (
    input  logic             clk,
    input  logic             rst,
    input  real              VIN,
    input  real              VREF,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic [NBITS-1:0] dout,
    output logic             clip
);
    import dms_sar_pkg::*;

    localparam int             IW      = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [IW-1:0]  IDX_MSB = IW'(NBITS - 1);

    if (NBITS < 2 || NBITS > 16 || !(TCLK > 0.0)) begin : g_bad_param
        $error("dms_sar_adc: NBITS must be 2..16 and TCLK positive");
    end

    sar_state_t       state, state_n;
    real              vin_h, vref_h;
    real              vin_s, vref_s;
    logic             clip_s, clip_n;
    logic [NBITS-1:0] code, code_n, trial;
    logic [IW-1:0]    idx;
    logic             keep;

`ifdef DMS_SAR_ADC_AVG_EN
    logic [1:0]       pass;
    logic [NBITS+1:0] acc;
`endif

    // Input conditioning applied at the SAMPLE edge: undriven nodes and bad references fall back.
    always_comb begin
        vref_s = VREF_NOM;
        if (VREF < DMS_XZ_LIMIT && VREF > 0.0)
            vref_s = VREF;
        vin_s = 0.0;
        if (VIN < DMS_XZ_LIMIT)
            vin_s = VIN;
        clip_s = (vin_s < 0.0) || (vin_s >= vref_s);
        if (vin_s < 0.0)
            vin_s = 0.0;
        else if (vin_s > vref_s)
            vin_s = vref_s;
    end

    always_comb begin
        trial      = code;
        trial[idx] = 1'b1;
        code_n     = keep ? trial : code;
    end

    dms_sar_cmp #(.NBITS(NBITS)) u_cmp (
        .vin_h  (vin_h),
        .vref_h (vref_h),
        .trial  (trial),
        .keep   (keep)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SAMPLE;
            SAMPLE:  state_n = CONVERT;
            CONVERT: begin
                if (idx == '0) begin
`ifdef DMS_SAR_ADC_AVG_EN
                    state_n = (pass == 2'd3) ? DONE : SAMPLE;
`else
                    state_n = DONE;
`endif
                end
            end
            DONE:    state_n = start ? SAMPLE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == SAMPLE) || (state == CONVERT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vin_h  <= 0.0;
            vref_h <= VREF_NOM;
            code   <= '0;
            idx    <= '0;
            clip_n <= 1'b0;
            dout   <= '0;
            clip   <= 1'b0;
            valid  <= 1'b0;
`ifdef DMS_SAR_ADC_AVG_EN
            pass   <= 2'd0;
            acc    <= '0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                SAMPLE: begin
                    vin_h  <= vin_s;
                    vref_h <= vref_s;
                    code   <= '0;
                    idx    <= IDX_MSB;
`ifdef DMS_SAR_ADC_AVG_EN
                    // First pass of a request restarts the accumulation.
                    if (pass == 2'd0) begin
                        clip_n <= clip_s;
                        acc    <= '0;
                    end else begin
                        clip_n <= clip_n | clip_s;
                    end
`else
                    clip_n <= clip_s;
`endif
                end
                CONVERT: begin
                    code <= code_n;
                    idx  <= idx - 1'b1;
`ifdef DMS_SAR_ADC_AVG_EN
                    if (idx == '0) begin
                        acc  <= acc + {2'b00, code_n};
                        pass <= pass + 2'd1;
                    end
`endif
                end
                DONE: begin
`ifdef DMS_SAR_ADC_AVG_EN
                    dout <= acc[NBITS+1:2];
`else
                    dout <= code;
`endif
                    clip  <= clip_n;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dms_sar_adc.sv
// Scoreboard bench for dms_sar_adc: random and directed conversions against an arithmetic reference.
module tb_dms_sar_adc;
    localparam int NBITS = 8;
    localparam int MAXC  = (1 << NBITS) - 1;
`ifdef DMS_SAR_ADC_AVG_EN
    localparam int LAT   = 4 * (NBITS + 1) + 1;
    localparam int BUSYC = 4 * (NBITS + 1);
`else
    localparam int LAT   = NBITS + 2;
    localparam int BUSYC = NBITS + 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    real              VIN = 0.0;
    real              VREF = 1.0;
    logic             busy, valid, clip;
    logic [NBITS-1:0] dout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    real nan_v;

    typedef struct {
        int code;
        bit clp;
        int edge_no;
    } exp_t;
    exp_t sb[$];

    dms_sar_adc #(.NBITS(NBITS), .VREF_NOM(1.0), .TCLK(10e-9)) dut (
        .clk   (clk),
        .rst   (rst),
        .VIN   (VIN),
        .VREF  (VREF),
        .start (start),
        .busy  (busy),
        .valid (valid),
        .dout  (dout),
        .clip  (clip)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void check(string name, longint act, longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: floor(vin*2^N/vref), saturated, with undriven/invalid inputs replaced.
    function automatic exp_t model(real vin, real vref, int edge_no);
        exp_t e;
        real  v = vin;
        real  r = vref;
        real  q;
        if (!(v < 1e20)) v = 0.0;
        if (!(r < 1e20) || r <= 0.0) r = 1.0;
        e.clp = (v < 0.0) || (v >= r);
        if (v < 0.0) begin
            e.code = 0;
        end else begin
            q = $floor(v * (2.0 ** NBITS) / r);
            e.code = (q > real'(MAXC)) ? MAXC : int'(q);
        end
        e.edge_no = edge_no;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: dout=%0d clip=%0d with no result pending", dout, clip);
            end else begin
                e = sb.pop_front();
                check("dout", dout, e.code);
                check("clip", clip, e.clp);
                check("valid_edge", cyc, e.edge_no);
            end
        end
    end

    task automatic run_conv(input real vin, input real vref, input bit mid_pulse);
        exp_t e;
        int   nb;
        @(negedge clk);
        VIN   = vin;
        VREF  = vref;
        start = 1'b1;
        e = model(vin, vref, cyc + 1 + LAT);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int i = 0; i < LAT + 5 && busy; i++) begin
            nb++;
            start = (mid_pulse && i == 3);
`ifndef DMS_SAR_ADC_AVG_EN
            if (i == 2) VIN = -5.0;
`endif
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", nb, BUSYC);
        repeat (4) @(negedge clk);
        check("dout_hold", dout, e.code);
        check("clip_hold", clip, e.clp);
        check("valid_low", valid, 0);
    endtask

    initial begin
        real vrefs[6];
        real rv, rr;
        int  k;
        nan_v = $bitstoreal(64'h7FF8_0000_0000_0000);
        vrefs = '{1.0, 0.5, 2.0, nan_v, 0.0, -1.0};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_dout", dout, 0);
        check("rst_clip", clip, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_conv(0.5, 1.0, 1'b1);
        run_conv(0.2, 1.0, 1'b0);
        run_conv(0.999, 1.0, 1'b1);
        run_conv(1.2, 1.0, 1'b0);
        run_conv(-0.1, 1.0, 1'b0);
        run_conv(nan_v, 1.0, 1'b0);
        run_conv(0.5, nan_v, 1'b0);
        run_conv(0.2, -2.0, 1'b0);

        // Reset four cycles into a conversion abandons it.
        @(negedge clk);
        VIN   = 0.7;
        VREF  = 1.0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_dout", dout, 0);
        check("abort_clip", clip, 0);
        @(negedge clk);
        rst = 1'b0;
        run_conv(0.25, 1.0, 1'b0);

        // Back-to-back with start held; VIN moves between the two samples.
        @(negedge clk);
        VIN   = 0.25;
        VREF  = 1.0;
        start = 1'b1;
        k = cyc + 1;
        sb.push_back(model(0.25, 1.0, k + LAT));
        sb.push_back(model(0.75, 1.0, k + 2 * LAT));
        repeat (LAT + 1) @(negedge clk);
        VIN   = 0.75;
        start = 1'b0;
        for (int i = 0; i < 3 * LAT && sb.size() > 0; i++) @(negedge clk);
        check("b2b_drained", sb.size(), 0);
        repeat (3) @(negedge clk);

        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 9))
                0:       rv = nan_v;
                1:       rv = -real'($urandom_range(1, 500)) / 1000.0;
                default: rv = real'($urandom_range(0, 2200)) / 1000.0;
            endcase
            rr = vrefs[$urandom_range(0, 5)];
            run_conv(rv, rr, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 3 * LAT && sb.size() > 0; i++) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dms_sar_adc.md
Name: dms_sar_adc

Overview:
- Successive-approximation ADC model that consumes the real-valued output of the CDR loop second-order low-pass filter.
- Converts the filter voltage to an N-bit code for the digital loop monitor/lock logic.
- Real-number model: analog input and reference are wreal1driver; control and code path are fully clocked logic.
- Sits directly downstream of the loop filter, between the analog RNM domain and the digital control domain.

Parameters:
- NBITS, 8: output code width (2..16).
- VREF_NOM, 1.0: reference voltage used when VREF is X/Z or <= 0.
- TCLK, 1e-9: not used internally; documents the expected clk period (s) for benches.

Ports:
- clk  input  1  conversion clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- VIN  input  wreal1driver  analog input (filter output).
- VREF  input  wreal1driver  full-scale reference voltage.
- start  input  1  conversion request, sampled on posedge clk.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  one-cycle pulse when dout/clip are updated.
- dout  output  NBITS  last completed conversion code, unsigned.
- clip  output  1  last conversion saturated (VIN < 0 or VIN >= VREF); updates with dout.

Behaviour:
- Reset: rst=1 asynchronously forces state IDLE, busy=0, valid=0, dout=0, clip=0, internal trial code=0, held sample=0.0. Reset mid-conversion abandons it; no valid pulse.
- FSM states: IDLE, SAMPLE, CONVERT, DONE.
- IDLE: start=1 -> SAMPLE.
- SAMPLE (1 cycle): vin_h = VIN, with X/Z (VIN not < 1e20) replaced by 0.0. vref_h = VREF, or VREF_NOM if X/Z or <= 0. clip_n = (vin_h < 0.0) || (vin_h >= vref_h). vin_h is clamped to [0, vref_h]. Code register cleared; bit index = NBITS-1. -> CONVERT.
- CONVERT (NBITS cycles, MSB first): trial = code | (1<<i). Keep the bit iff vin_h >= trial*vref_h/2**NBITS. Index decrements; after bit 0 -> DONE.
- DONE (1 cycle): dout = code, clip = clip_n, valid=1. start=1 -> SAMPLE (back-to-back), else -> IDLE.
- busy = 1 in SAMPLE and CONVERT, 0 in IDLE and DONE.
- start in SAMPLE or CONVERT is ignored; it is not queued.
- Latency: start seen at edge k -> valid at edge k+NBITS+2. Back-to-back throughput: one result per NBITS+2 cycles.
- Result equals floor(vin_h*2**NBITS/vref_h), saturated to 2**NBITS-1.
- VIN changes after SAMPLE do not affect the conversion in progress.
- dout and clip hold between valid pulses.

Optional Feature:
- Macro DMS_SAR_ADC_AVG_EN.
- Defined: each start runs 4 consecutive sample+convert passes, with a 2-bit pass counter and an (NBITS+2)-bit accumulator. dout = accumulator >> 2 (truncating). clip = OR of the four passes. busy stays high through all passes. valid fires once, at edge k+4*(NBITS+1)+1.
- Undefined: single pass as described above; no counter or accumulator logic is present.

Decomposition:
- Package dms_sar_pkg: state enum typedef sar_state_t {IDLE, SAMPLE, CONVERT, DONE}; constant DMS_XZ_LIMIT = 1e20.
- wreal1driver comes from cds_rnm_pkg.
- One sub-module, dms_sar_cmp: combinational real comparator. Inputs vin_h, vref_h, trial code; output keep bit. Isolates real arithmetic from the FSM.

Test Plan:
- NBITS=8, VREF=1.0, VIN=0.5, start pulse -> valid at edge +10, dout=128, clip=0, busy high 9 cycles.
- VIN=0.2 -> dout=51. VIN=0.999 -> dout=255, clip=0.
- VIN=1.2 -> dout=255, clip=1. VIN=-0.1 -> dout=0, clip=1. VIN=Z -> dout=0, clip=0.
- rst asserted 4 cycles after start -> busy/valid/dout drop to 0 immediately, no valid pulse. A later start with VIN=0.25 -> dout=64.
- start held high continuously, VIN stepped 0.25 -> 0.75 between samples -> valid every 10 cycles, dout 64 then 192. start pulses during CONVERT produce no extra results.
- With DMS_SAR_ADC_AVG_EN, VIN=0.5 constant -> single valid at edge +37, dout=128. VREF=X -> VREF_NOM used, same codes as VREF=1.0.
